// File: rtl/core_pkg.sv
// Shared types for the fetch/decode/execute front end: decoded-instruction record,
// ALU operation codes, fetch states, RV32I opcode constants and the decoder function.
package core_pkg;

   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;

   typedef enum logic [4:0] {
      ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
      ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B, ALU_ADD_PC,
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
   } alu_op_t;

   typedef enum logic {F_IDLE, F_WAIT} fetch_state_t;

   // uses_reg = {reads rs2, reads rs1}; rs1/rs2 are zeroed when not read so a
   // forwarding key can never hit an immediate field.
   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      alu_op_t     alu_op;
      logic        is_load;
      logic        is_store;
      logic        is_branch;
      logic        is_jal;
      logic        is_jalr;
      logic        writes_to_reg;
      logic [1:0]  uses_reg;
   } instr_t;

   function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic sub,
                                           input logic sra);
      alu_op_t op;
      case (f3)
         3'd0:    op = sub ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = sra ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic alu_op_t branch_from_f3(input logic [2:0] f3);
      alu_op_t op;
      case (f3)
         3'd0:    op = ALU_BEQ;
         3'd1:    op = ALU_BNE;
         3'd4:    op = ALU_BLT;
         3'd5:    op = ALU_BGE;
         3'd6:    op = ALU_BLTU;
         3'd7:    op = ALU_BGEU;
         default: op = ALU_NOP;
      endcase
      return op;
   endfunction

   function automatic instr_t decode(input logic [31:0] raw, input logic [31:0] pc);
      instr_t      d;
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
      imm_i = {{20{raw[31]}}, raw[31:20]};
      imm_s = {{20{raw[31]}}, raw[31:25], raw[11:7]};
      imm_b = {{20{raw[31]}}, raw[7], raw[30:25], raw[11:8], 1'b0};
      imm_u = {raw[31:12], 12'h000};
      imm_j = {{12{raw[31]}}, raw[19:12], raw[20], raw[30:21], 1'b0};
      d = '0;
      d.pc = pc;
      case (raw[6:0])
         OPC_LUI: begin
            d.rd = raw[11:7]; d.imm = imm_u; d.alu_op = ALU_PASS_B;
         end
         OPC_AUIPC: begin
            d.rd = raw[11:7]; d.imm = imm_u; d.alu_op = ALU_ADD_PC;
         end
         OPC_JAL: begin
            d.rd = raw[11:7]; d.imm = imm_j; d.alu_op = ALU_ADD_PC; d.is_jal = 1'b1;
         end
         OPC_JALR: begin
            d.rd = raw[11:7]; d.imm = imm_i; d.alu_op = ALU_ADD_PC; d.is_jalr = 1'b1;
            d.uses_reg = 2'b01;
         end
         OPC_BRANCH: begin
            d.imm = imm_b; d.alu_op = branch_from_f3(raw[14:12]); d.is_branch = 1'b1;
            d.uses_reg = 2'b11;
         end
         OPC_LOAD: begin
            d.rd = raw[11:7]; d.imm = imm_i; d.alu_op = ALU_ADD; d.is_load = 1'b1;
            d.uses_reg = 2'b01;
         end
         OPC_STORE: begin
            d.imm = imm_s; d.alu_op = ALU_ADD; d.is_store = 1'b1; d.uses_reg = 2'b11;
         end
         OPC_OPIMM: begin
            d.rd = raw[11:7]; d.imm = imm_i; d.uses_reg = 2'b01;
            d.alu_op = alu_from_f3(raw[14:12], 1'b0, raw[30]);
         end
         OPC_OP: begin
            d.rd = raw[11:7]; d.uses_reg = 2'b11;
            d.alu_op = alu_from_f3(raw[14:12], raw[30], raw[30]);
         end
         default: ;
      endcase
      if (d.uses_reg[0]) d.rs1 = raw[19:15];
      if (d.uses_reg[1]) d.rs2 = raw[24:20];
      d.writes_to_reg = (d.rd != 5'd0);
      return d;
   endfunction

endpackage

// File: rtl/fde_alu.sv
// Combinational RV32I ALU and branch comparator for the execute stage.
module fde_alu
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  alu_op_t         op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] res_o,
   output logic            cmp_o
);

   logic [4:0] shamt;
   assign shamt = b_i[4:0];

   always_comb begin
      res_o = '0;
      cmp_o = 1'b0;
      case (op_i)
         ALU_ADD, ALU_ADD_PC: res_o = a_i + b_i;
         ALU_SUB:    res_o = a_i - b_i;
         ALU_SLL:    res_o = a_i << shamt;
         ALU_SLT:    res_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
         ALU_SLTU:   res_o = {{(XLEN-1){1'b0}}, a_i < b_i};
         ALU_XOR:    res_o = a_i ^ b_i;
         ALU_SRL:    res_o = a_i >> shamt;
         ALU_SRA:    res_o = $unsigned($signed(a_i) >>> shamt);
         ALU_OR:     res_o = a_i | b_i;
         ALU_AND:    res_o = a_i & b_i;
         ALU_PASS_B: res_o = b_i;
         ALU_BEQ:    cmp_o = (a_i == b_i);
         ALU_BNE:    cmp_o = (a_i != b_i);
         ALU_BLT:    cmp_o = ($signed(a_i) < $signed(b_i));
         ALU_BGE:    cmp_o = ($signed(a_i) >= $signed(b_i));
         ALU_BLTU:   cmp_o = (a_i < b_i);
         ALU_BGEU:   cmp_o = (a_i >= b_i);
         default: ;
      endcase
   end

endmodule

// File: rtl/fetch_decode_execute.sv
// Fetch / decode / execute front end of the RV32I pipeline, stepped by per-stage pulses.
// Define FDE_FORWARDING_EN to enable the one-entry operand forwarding path.
//
// fetch state | meaning
// F_IDLE      | no ROM read outstanding
// F_WAIT      | rom_addr issued, ROM word captured on the next edge
module fetch_decode_execute
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            fetch_en,
   input  logic            decode_en,
   input  logic            exec_en,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] rom_addr,
   input  logic [XLEN-1:0] rom_data,
   output logic            fetch_done,
   output logic            decode_done,
   output logic            exec_done,
   output logic [XLEN-1:0] instr_raw,
   output logic [XLEN-1:0] pc_n,
   output logic [4:0]      rs1_a,
   output logic [4:0]      rs2_a,
   input  logic [XLEN-1:0] rs1_v,
   input  logic [XLEN-1:0] rs2_v,
   output instr_t          instr_d,
   output instr_t          instr_e,
   output logic [XLEN-1:0] rs1_e,
   output logic [XLEN-1:0] rs2_e,
   input  logic            fwd_en,
   input  logic [4:0]      fwd_key,
   input  logic [XLEN-1:0] fwd_value,
   output logic [XLEN-1:0] result,
   output logic            jump_taken,
   output logic [XLEN-1:0] jump_dest
);

   fetch_state_t    fstate_q;
   logic [XLEN-1:0] rom_addr_q, instr_raw_q, pc_n_q;
   logic            fetch_done_q;
   instr_t          instr_d_q, instr_e_q;
   logic [XLEN-1:0] rs1_q, rs2_q;
   logic            decode_done_q;
   logic [XLEN-1:0] rs1_e_q, rs2_e_q, result_q, jump_dest_q;
   logic            jump_taken_q, exec_done_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fstate_q     <= F_IDLE;
         rom_addr_q   <= '0;
         instr_raw_q  <= '0;
         pc_n_q       <= '0;
         fetch_done_q <= 1'b0;
      end else begin
         case (fstate_q)
            F_WAIT: begin
               instr_raw_q  <= rom_data;
               pc_n_q       <= rom_addr_q;
               fetch_done_q <= 1'b1;
               fstate_q     <= F_IDLE;
            end
            default: ;
         endcase
         // A new pulse restarts the fetch even if a word is still outstanding.
         if (fetch_en) begin
            rom_addr_q   <= pc;
            fetch_done_q <= 1'b0;
            fstate_q     <= F_WAIT;
         end
      end
   end

   assign rs1_a = instr_raw_q[19:15];
   assign rs2_a = instr_raw_q[24:20];

   logic fwd1, fwd2;
`ifdef FDE_FORWARDING_EN
   assign fwd1 = fwd_en && (fwd_key != 5'd0) && (fwd_key == instr_d_q.rs1);
   assign fwd2 = fwd_en && (fwd_key != 5'd0) && (fwd_key == instr_d_q.rs2);
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_en, fwd_key, fwd_value};
   assign fwd1 = 1'b0;
   assign fwd2 = 1'b0;
`endif

   logic [XLEN-1:0] op1, op2, alu_a, alu_b, alu_res, dest_d;
   logic            cmp, taken_d;

   assign op1 = fwd1 ? fwd_value : rs1_q;
   assign op2 = fwd2 ? fwd_value : rs2_q;

   // Jumps reuse the adder to form the link address pc+4.
   always_comb begin
      alu_a = (instr_d_q.alu_op == ALU_ADD_PC) ? instr_d_q.pc : op1;
      if (instr_d_q.is_jal || instr_d_q.is_jalr)
         alu_b = 32'd4;
      else if (instr_d_q.uses_reg[1] && !instr_d_q.is_store)
         alu_b = op2;
      else
         alu_b = instr_d_q.imm;
   end

   fde_alu #(.XLEN(XLEN)) u_alu (
      .op_i  (instr_d_q.alu_op),
      .a_i   (alu_a),
      .b_i   (alu_b),
      .res_o (alu_res),
      .cmp_o (cmp)
   );

   always_comb begin
      taken_d = instr_d_q.is_jal || instr_d_q.is_jalr || (instr_d_q.is_branch && cmp);
      if (instr_d_q.is_jalr)
         dest_d = (op1 + instr_d_q.imm) & ~32'd1;
      else if (instr_d_q.is_jal || instr_d_q.is_branch)
         dest_d = instr_d_q.pc + instr_d_q.imm;
      else
         dest_d = '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         instr_d_q     <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         decode_done_q <= 1'b0;
         instr_e_q     <= '0;
         rs1_e_q       <= '0;
         rs2_e_q       <= '0;
         result_q      <= '0;
         jump_taken_q  <= 1'b0;
         jump_dest_q   <= '0;
         exec_done_q   <= 1'b0;
      end else begin
         if (decode_en) begin
            instr_d_q     <= decode(instr_raw_q, pc_n_q);
            rs1_q         <= rs1_v;
            rs2_q         <= rs2_v;
            decode_done_q <= 1'b1;
         end
         if (exec_en) begin
            instr_e_q    <= instr_d_q;
            rs1_e_q      <= op1;
            rs2_e_q      <= op2;
            result_q     <= alu_res;
            jump_taken_q <= taken_d;
            jump_dest_q  <= dest_d;
            exec_done_q  <= 1'b1;
         end
      end
   end

   assign rom_addr    = rom_addr_q;
   assign instr_raw   = instr_raw_q;
   assign pc_n        = pc_n_q;
   assign fetch_done  = fetch_done_q;
   assign instr_d     = instr_d_q;
   assign decode_done = decode_done_q;
   assign instr_e     = instr_e_q;
   assign rs1_e       = rs1_e_q;
   assign rs2_e       = rs2_e_q;
   assign result      = result_q;
   assign jump_taken  = jump_taken_q;
   assign jump_dest   = jump_dest_q;
   assign exec_done   = exec_done_q;

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Directed bench for fetch_decode_execute with a per-cycle behavioural model compare.
module tb_fetch_decode_execute;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        fetch_en = 1'b0, decode_en = 1'b0, exec_en = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] rom_addr, rom_data, instr_raw, pc_n, rs1_v, rs2_v;
   logic        fetch_done, decode_done, exec_done;
   logic [4:0]  rs1_a, rs2_a;
   instr_t      instr_d, instr_e;
   logic [31:0] rs1_e, rs2_e, result, jump_dest;
   logic        jump_taken;
   logic        fwd_en = 1'b0;
   logic [4:0]  fwd_key = '0;
   logic [31:0] fwd_value = '0;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] rom  [0:63];
   logic [31:0] regs [0:31];

   always #5 clk = ~clk;

   assign rom_data = rom[rom_addr[7:2]];
   assign rs1_v    = regs[rs1_a];
   assign rs2_v    = regs[rs2_a];

   fetch_decode_execute #(.XLEN(32)) dut (
      .clk(clk), .rstn(rstn), .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
      .pc(pc), .rom_addr(rom_addr), .rom_data(rom_data),
      .fetch_done(fetch_done), .decode_done(decode_done), .exec_done(exec_done),
      .instr_raw(instr_raw), .pc_n(pc_n), .rs1_a(rs1_a), .rs2_a(rs2_a),
      .rs1_v(rs1_v), .rs2_v(rs2_v), .instr_d(instr_d), .instr_e(instr_e),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .fwd_en(fwd_en), .fwd_key(fwd_key), .fwd_value(fwd_value),
      .result(result), .jump_taken(jump_taken), .jump_dest(jump_dest)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        ld, st, br, jal, jalr, wr;
   } dexp_t;

   typedef struct packed {
      logic [31:0] res;
      logic        taken;
      logic [31:0] dest;
   } eexp_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic dexp_t dut_fields(input instr_t i);
      return '{i.pc, i.rd, i.rs1, i.rs2, i.imm, i.is_load, i.is_store, i.is_branch,
               i.is_jal, i.is_jalr, i.writes_to_reg};
   endfunction

   // Reference decoder from the RV32I encoding tables.
   function automatic dexp_t exp_decode(input logic [31:0] w, input logic [31:0] p);
      dexp_t e;
      logic [31:0] ii, is_, ib, iu, ij;
      ii  = {{20{w[31]}}, w[31:20]};
      is_ = {{20{w[31]}}, w[31:25], w[11:7]};
      ib  = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
      iu  = {w[31:12], 12'h000};
      ij  = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
      e = '0;
      e.pc = p;
      case (w[6:0])
         7'h37, 7'h17: begin e.rd = w[11:7]; e.imm = iu; end
         7'h6F: begin e.rd = w[11:7]; e.imm = ij; e.jal = 1'b1; end
         7'h67: begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = ii; e.jalr = 1'b1; end
         7'h63: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = ib; e.br = 1'b1; end
         7'h03: begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = ii; e.ld = 1'b1; end
         7'h23: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = is_; e.st = 1'b1; end
         7'h13: begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = ii; end
         7'h33: begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
         default: ;
      endcase
      e.wr = (e.rd != 5'd0);
      return e;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] x,
                                          input logic [31:0] y, input logic sub,
                                          input logic arith);
      case (f3)
         3'd0: return sub ? x - y : x + y;
         3'd1: return x << y[4:0];
         3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         3'd3: return (x < y) ? 32'd1 : 32'd0;
         3'd4: return x ^ y;
         3'd5: return arith ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
         3'd6: return x | y;
         default: return x & y;
      endcase
   endfunction

   function automatic eexp_t exp_exec(input logic [31:0] w, input logic [31:0] p,
                                      input logic [31:0] a, input logic [31:0] b);
      eexp_t r;
      dexp_t d;
      logic [2:0] f3;
      r = '0;
      d = exp_decode(w, p);
      f3 = w[14:12];
      case (w[6:0])
         7'h37: r.res = d.imm;
         7'h17: r.res = p + d.imm;
         7'h6F: begin r.res = p + 4; r.taken = 1'b1; r.dest = p + d.imm; end
         7'h67: begin r.res = p + 4; r.taken = 1'b1; r.dest = (a + d.imm) & 32'hFFFF_FFFE; end
         7'h63: begin
            r.dest = p + d.imm;
            case (f3)
               3'd0: r.taken = (a == b);
               3'd1: r.taken = (a != b);
               3'd4: r.taken = ($signed(a) < $signed(b));
               3'd5: r.taken = ($signed(a) >= $signed(b));
               3'd6: r.taken = (a < b);
               3'd7: r.taken = (a >= b);
               default: r.taken = 1'b0;
            endcase
         end
         7'h03, 7'h23: r.res = a + d.imm;
         7'h13: r.res = ref_alu(f3, a, d.imm, 1'b0, w[30]);
         7'h33: r.res = ref_alu(f3, a, b, w[30], w[30]);
         default: ;
      endcase
      return r;
   endfunction

   function automatic logic fwd_hit(input logic [4:0] src);
`ifdef FDE_FORWARDING_EN
      return fwd_en && (fwd_key != 5'd0) && (fwd_key == src);
`else
      return (src == 5'd31) && 1'b0;
`endif
   endfunction

   // Model state: what each stage must be showing, per the stage timing rules.
   logic [31:0] m_romaddr, m_raw, m_pcn, m_dword, m_dpc, m_r1, m_r2;
   logic [31:0] m_eword, m_epc, m_e1, m_e2;
   logic        m_pend, m_fdone, m_ddone, m_edone;
   eexp_t       m_ex;

   always @(posedge clk or negedge rstn) begin : model
      dexp_t dd;
      logic [31:0] o1, o2;
      if (!rstn) begin
         m_romaddr <= '0; m_raw <= '0; m_pcn <= '0; m_pend <= 1'b0; m_fdone <= 1'b0;
         m_dword <= '0; m_dpc <= '0; m_r1 <= '0; m_r2 <= '0; m_ddone <= 1'b0;
         m_eword <= '0; m_epc <= '0; m_e1 <= '0; m_e2 <= '0; m_ex <= '0; m_edone <= 1'b0;
      end else begin
         if (m_pend) begin
            m_raw <= rom[m_romaddr[7:2]]; m_pcn <= m_romaddr; m_fdone <= 1'b1; m_pend <= 1'b0;
         end
         if (fetch_en) begin
            m_romaddr <= pc; m_fdone <= 1'b0; m_pend <= 1'b1;
         end
         if (decode_en) begin
            m_dword <= m_raw; m_dpc <= m_pcn; m_ddone <= 1'b1;
            m_r1 <= regs[m_raw[19:15]]; m_r2 <= regs[m_raw[24:20]];
         end
         if (exec_en) begin
            dd = exp_decode(m_dword, m_dpc);
            o1 = fwd_hit(dd.rs1) ? fwd_value : m_r1;
            o2 = fwd_hit(dd.rs2) ? fwd_value : m_r2;
            m_eword <= m_dword; m_epc <= m_dpc; m_e1 <= o1; m_e2 <= o2;
            m_ex <= exp_exec(m_dword, m_dpc, o1, o2); m_edone <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      chk("rom_addr", 128'(rom_addr), 128'(m_romaddr));
      chk("fetch_done", 128'(fetch_done), 128'(m_fdone));
      chk("instr_raw", 128'(instr_raw), 128'(m_raw));
      chk("pc_n", 128'(pc_n), 128'(m_pcn));
      chk("rs_addr", 128'({rs1_a, rs2_a}), 128'({m_raw[19:15], m_raw[24:20]}));
      chk("decode_done", 128'(decode_done), 128'(m_ddone));
      chk("instr_d", 128'(dut_fields(instr_d)), 128'(exp_decode(m_dword, m_dpc)));
      chk("exec_done", 128'(exec_done), 128'(m_edone));
      chk("instr_e", 128'(dut_fields(instr_e)), 128'(exp_decode(m_eword, m_epc)));
      chk("rs1_e", 128'(rs1_e), 128'(m_e1));
      chk("rs2_e", 128'(rs2_e), 128'(m_e2));
      chk("result", 128'(result), 128'(m_ex.res));
      chk("jump_taken", 128'(jump_taken), 128'(m_ex.taken));
      chk("jump_dest", 128'(jump_dest), 128'(m_ex.dest));
   end

   // All tasks start and end on a falling edge.
   task automatic do_fetch(input logic [31:0] a);
      pc = a; fetch_en = 1'b1;
      @(negedge clk); fetch_en = 1'b0;
      chk("fetch_pending_low", 128'(fetch_done), 128'(0));
      @(negedge clk);
      chk("fetch_latency2", 128'(fetch_done), 128'(1));
   endtask

   task automatic do_decode();
      decode_en = 1'b1; @(negedge clk); decode_en = 1'b0;
   endtask

   task automatic do_exec();
      exec_en = 1'b1; @(negedge clk); exec_en = 1'b0;
   endtask

   task automatic run(input logic [31:0] a);
      do_fetch(a); do_decode(); do_exec();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 32'h0000_0013;
      for (int i = 0; i < 32; i++) regs[i] = '0;
      rom[2]  = 32'h0050_0093;  // 0x08 ADDI x1,x0,5
      rom[8]  = 32'hFE20_8CE3;  // 0x20 BEQ x1,x2,-8
      rom[16] = 32'h0081_00E7;  // 0x40 JALR x1,8(x2)
      rom[17] = 32'h0020_81B3;  // 0x44 ADD x3,x1,x2
      rom[18] = 32'h0000_007F;  // 0x48 undefined opcode
      rom[19] = 32'h4020_8233;  // 0x4C SUB x4,x1,x2
      rom[20] = 32'h4043_5293;  // 0x50 SRAI x5,x6,4
      rom[21] = 32'h1234_53B7;  // 0x54 LUI x7,0x12345
      rom[22] = 32'h0000_1417;  // 0x58 AUIPC x8,1
      rom[23] = 32'h0100_00EF;  // 0x5C JAL x1,+16
      rom[24] = 32'h0020_A623;  // 0x60 SW x2,12(x1)
      rom[25] = 32'h0014_C463;  // 0x64 BLT x9,x1,+8
      rom[26] = 32'h0014_B533;  // 0x68 SLTU x10,x9,x1

      // Enables while in reset must be ignored.
      @(negedge clk); pc = 32'h8; fetch_en = 1'b1; decode_en = 1'b1; exec_en = 1'b1;
      @(negedge clk); fetch_en = 1'b0; decode_en = 1'b0; exec_en = 1'b0;
      #2 rstn = 1'b1;
      @(negedge clk);
      chk("reset_fetch_done", 128'(fetch_done), 128'(0));
      chk("reset_rom_addr", 128'(rom_addr), 128'(0));
      chk("reset_exec_done", 128'(exec_done), 128'(0));

      do_fetch(32'h8);
      chk("addi_raw", 128'(instr_raw), 128'(32'h0050_0093));
      chk("addi_pc_n", 128'(pc_n), 128'(8));
      chk("addi_rs1_a", 128'(rs1_a), 128'(0));
      do_decode();
      chk("addi_rd", 128'(instr_d.rd), 128'(1));
      chk("addi_imm", 128'(instr_d.imm), 128'(5));
      chk("addi_wr", 128'(instr_d.writes_to_reg), 128'(1));
      do_exec();
      chk("addi_result", 128'(result), 128'(5));
      chk("addi_taken", 128'(jump_taken), 128'(0));

      regs[1] = 32'd7; regs[2] = 32'd7;
      run(32'h20);
      chk("beq_taken", 128'(jump_taken), 128'(1));
      chk("beq_dest", 128'(jump_dest), 128'(32'h18));
      regs[2] = 32'd8;
      do_decode(); do_exec();
      chk("beq_not_taken", 128'(jump_taken), 128'(0));

      regs[2] = 32'h101;
      run(32'h40);
      chk("jalr_result", 128'(result), 128'(32'h44));
      chk("jalr_dest", 128'(jump_dest), 128'(32'h108));
      chk("jalr_taken", 128'(jump_taken), 128'(1));

      regs[1] = 32'd1; regs[2] = 32'd2;
      do_fetch(32'h44); do_decode();
      fwd_en = 1'b1; fwd_key = 5'd1; fwd_value = 32'd10;
      do_exec();
`ifdef FDE_FORWARDING_EN
      chk("fwd_rs1_result", 128'(result), 128'(12));
`else
      chk("nofwd_rs1_result", 128'(result), 128'(3));
`endif
      fwd_key = 5'd0;
      do_exec();
      chk("fwd_key0_result", 128'(result), 128'(3));
      fwd_key = 5'd2; fwd_value = 32'd20;
      do_exec();
`ifdef FDE_FORWARDING_EN
      chk("fwd_rs2_result", 128'(result), 128'(21));
`else
      chk("nofwd_rs2_result", 128'(result), 128'(3));
`endif
      fwd_en = 1'b0; fwd_key = '0; fwd_value = '0;

      run(32'h48);
      chk("undef_flags", 128'({instr_d.is_load, instr_d.is_store, instr_d.is_branch,
                               instr_d.is_jal, instr_d.is_jalr, instr_d.writes_to_reg}),
          128'(0));
      chk("undef_result", 128'(result), 128'(0));
      chk("undef_taken", 128'(jump_taken), 128'(0));

      regs[6] = 32'h8000_0010; regs[9] = 32'hFFFF_FFFF;
      for (int k = 0; k < 8; k++) begin
         run(32'h4C + 32'(4 * k));
         if (k == 1) chk("srai_result", 128'(result), 128'(32'hF800_0001));
      end

      repeat (3) @(negedge clk);

      // Reset with a fetch outstanding drops the pending word.
      pc = 32'h20; fetch_en = 1'b1;
      @(negedge clk); fetch_en = 1'b0;
      #2 rstn = 1'b0;
      @(negedge clk);
      #2 rstn = 1'b1;
      repeat (2) @(negedge clk);
      chk("midreset_done", 128'(fetch_done), 128'(0));
      chk("midreset_raw", 128'(instr_raw), 128'(0));
      do_fetch(32'h20);
      chk("refetch_raw", 128'(instr_raw), 128'(32'hFE20_8CE3));

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
